// File: rtl/pool_stream_layer.sv
// pool_stream_layer: streaming k x k non-overlapping max/avg pooling over a
// channel-parallel raster pixel stream, with valid/ready input, stall-aware
// output and a frame-done pulse.
//
// state | meaning
// IDLE  | waiting for i_start, input not ready
// RUN   | accepting pixels, accumulating windows
// DRAIN | all pixels taken, waiting for the last result to be consumed
module pool_stream_layer #(
  parameter int input_channels       = 5,
  parameter int img_width            = 24,
  parameter int kernel_dim           = 2,
  parameter int datatype_size        = 4,
  parameter int output_datatype_size = 4,
  parameter int out_width            = img_width / kernel_dim
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  i_start,
  input  logic                                                  i_mode,
  input  logic                                                  i_valid,
  input  logic [input_channels-1:0][datatype_size-1:0]          i_data,
  output logic                                                  o_ready,
  input  logic                                                  i_next_busy,
  output logic                                                  o_valid,
  output logic [input_channels-1:0][output_datatype_size-1:0]   o_func_data,
  output logic                                                  o_busy,
  output logic                                                  o_done
);

  localparam int lk        = $clog2(kernel_dim);
  localparam int acc_w     = datatype_size + 2 * lk;
  // Counters are wide enough to hold img_width itself so the in-range limit
  // never wraps to zero when the image side is a power of two.
  localparam int cw        = $clog2(img_width + 1);
  // One spare accumulator column when img_width is not a multiple of the
  // kernel, so the out-of-range column index still reads a real entry.
  localparam int acc_depth = (img_width + kernel_dim - 1) / kernel_dim;
  localparam int idx_w     = (acc_depth > 1) ? $clog2(acc_depth) : 1;
  localparam logic [cw-1:0] lim      = cw'(out_width * kernel_dim);
  localparam logic [cw-1:0] last_pos = cw'(img_width - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [cw-1:0]     row;
  logic [cw-1:0]     col;
  logic              mode;
  logic [acc_w-1:0]  acc [acc_depth][input_channels];
  logic [acc_w-1:0]  pix [input_channels];
  logic [acc_w-1:0]  cur [input_channels];
  logic [acc_w-1:0]  nxt [input_channels];
  logic [acc_w-1:0]  res [input_channels];
  logic [idx_w-1:0]  win;
  logic              accept;
  logic              in_range;
  logic              first_el;
  logic              last_el;
  logic              frame_end;
  logic              consume;

  assign win       = idx_w'(col >> lk);
  assign in_range  = (row < lim) && (col < lim);
  assign first_el  = (row[lk-1:0] == '0) && (col[lk-1:0] == '0);
  assign last_el   = in_range && (&row[lk-1:0]) && (&col[lk-1:0]);
  assign frame_end = (row == last_pos) && (col == last_pos);
  assign consume   = o_valid && !i_next_busy;
  assign o_ready   = (state == RUN) && !(o_valid && i_next_busy);
  assign accept    = i_valid && o_ready && !i_start;
  assign o_busy    = (state != IDLE) || o_valid;

  // Per-channel accumulator update and the pooled result it would produce.
  always_comb begin
    for (int ch = 0; ch < input_channels; ch++) begin
      pix[ch] = acc_w'(i_data[ch]);
      cur[ch] = acc[win][ch];
      if (first_el)
        nxt[ch] = pix[ch];
      else if (mode)
        nxt[ch] = cur[ch] + pix[ch];
      else
        nxt[ch] = (pix[ch] > cur[ch]) ? pix[ch] : cur[ch];
      res[ch] = mode ? (nxt[ch] >> (2 * lk)) : nxt[ch];
    end
  end

  // Control FSM, raster counters, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      mode        <= 1'b0;
      o_valid     <= 1'b0;
      o_func_data <= '0;
      o_done      <= 1'b0;
      for (int d = 0; d < acc_depth; d++)
        for (int ch = 0; ch < input_channels; ch++)
          acc[d][ch] <= '0;
    end else begin
      o_done <= 1'b0;
      if (consume)
        o_valid <= 1'b0;
      if (i_start) begin
        // Start from IDLE and restart mid-frame share one path; a pending
        // result is dropped and no done pulse is produced.
        state   <= RUN;
        row     <= '0;
        col     <= '0;
        mode    <= i_mode;
        o_valid <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (accept) begin
              if (in_range)
                for (int ch = 0; ch < input_channels; ch++)
                  acc[win][ch] <= nxt[ch];
              if (last_el) begin
                o_valid <= 1'b1;
                for (int ch = 0; ch < input_channels; ch++)
                  o_func_data[ch] <= output_datatype_size'(res[ch]);
              end
              if (col == last_pos) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              if (frame_end)
                state <= DRAIN;
            end
          end
          DRAIN: begin
            if (!o_valid || consume) begin
              state  <= IDLE;
              o_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
